// File: rtl/m68k_io_latch_if.sv
`default_nettype none
// ============================================================================
//  Module   : m68k_io_latch_if
//  Purpose  : Bus bundle between chip_select / CPU pins and m68k_io_latch.
//             The 68k write bus, decoded selects, Z80 IO strobes and every
//             latched output.
//  Revision : 1.0  initial release
// ============================================================================
interface m68k_io_latch_if;
    logic [2:0]  pcb;
    logic [15:0] m68k_din;
    logic        m68k_rw;
    logic        m68k_uds_n;
    logic        m68k_lds_n;
    logic        irq_z80_cs;
    logic        bg_scroll_x_cs;
    logic        bg_scroll_y_cs;
    logic        fg_scroll_x_cs;
    logic        fg_scroll_y_cs;
    logic        sound_latch_cs;
    logic        irq_ack_cs;
    logic        vbl;
    logic        z80_latch_r_cs;
    logic        z80_latch_clr_cs;
    logic        z80_m1_n;
    logic        z80_iorq_n;
    logic [2:0]  m68k_ipl_n;
    logic        z80_int_n;
    logic [7:0]  z80_latch_dout;
    logic        latch_full;
    logic [15:0] io_reg;
    logic        flip_screen;
    logic [9:0]  bg_scroll_x;
    logic [9:0]  bg_scroll_y;
    logic [9:0]  fg_scroll_x;
    logic [9:0]  fg_scroll_y;

    // Driver side: CPU bus, chip_select and Z80 glue.
    modport master (
        output pcb, m68k_din, m68k_rw, m68k_uds_n, m68k_lds_n,
        output irq_z80_cs, bg_scroll_x_cs, bg_scroll_y_cs, fg_scroll_x_cs,
        output fg_scroll_y_cs, sound_latch_cs, irq_ack_cs, vbl,
        output z80_latch_r_cs, z80_latch_clr_cs, z80_m1_n, z80_iorq_n,
        input  m68k_ipl_n, z80_int_n, z80_latch_dout, latch_full, io_reg,
        input  flip_screen, bg_scroll_x, bg_scroll_y, fg_scroll_x, fg_scroll_y
    );

    // Register stage side.
    modport slave (
        input  pcb, m68k_din, m68k_rw, m68k_uds_n, m68k_lds_n,
        input  irq_z80_cs, bg_scroll_x_cs, bg_scroll_y_cs, fg_scroll_x_cs,
        input  fg_scroll_y_cs, sound_latch_cs, irq_ack_cs, vbl,
        input  z80_latch_r_cs, z80_latch_clr_cs, z80_m1_n, z80_iorq_n,
        output m68k_ipl_n, z80_int_n, z80_latch_dout, latch_full, io_reg,
        output flip_screen, bg_scroll_x, bg_scroll_y, fg_scroll_x, fg_scroll_y
    );
endinterface
`default_nettype wire

// File: rtl/m68k_io_latch.sv
`default_nettype none
// ============================================================================
//  Module   : m68k_io_latch
//  Purpose  : Register/interrupt stage behind chip_select (clk_sys domain).
//             Video control word, four scroll registers, 68k->Z80 sound
//             latch, 68k vblank IRQ with ack, periodic Z80 IRQ.
//             irq_z80_cs selects the video control word (armedf_io/terraf_io
//             register shares that decode on these boards).
//  Revision : 1.0  initial release
// ============================================================================
module m68k_io_latch #(
    parameter int Z80_IRQ_DIV = 2048
) (
    input  logic           clk_sys,
    input  logic           reset,
    m68k_io_latch_if.slave bus
);

    localparam int               CNT_W    = (Z80_IRQ_DIV > 2) ? $clog2(Z80_IRQ_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(Z80_IRQ_DIV - 1);

    // Select index map inside the write-strobe vector.
    localparam int SEL_IO  = 0;
    localparam int SEL_BGX = 1;
    localparam int SEL_BGY = 2;
    localparam int SEL_FGX = 3;
    localparam int SEL_FGY = 4;
    localparam int SEL_SND = 5;
    localparam int SEL_ACK = 6;
    localparam int NSEL    = 7;

    logic [NSEL-1:0]  sel;
    logic             wr_cycle;
    logic [NSEL-1:0]  wr_lvl;
    logic [NSEL-1:0]  strobe;
    logic             vbl_rise;
    logic             clr_pulse;
    logic             z80_ack_lvl;
    logic             z80_ack;
    logic             term;
    logic [2:0]       irq_level;

    logic [NSEL-1:0]  wr_q,        wr_d;
    logic             vbl_q,       vbl_d;
    logic             clr_q,       clr_d;
    logic             ack_q,       ack_d;
    logic [15:0]      io_reg_q,    io_reg_d;
    logic [9:0]       bgx_q,       bgx_d;
    logic [9:0]       bgy_q,       bgy_d;
    logic [9:0]       fgx_q,       fgx_d;
    logic [9:0]       fgy_q,       fgy_d;
    logic [7:0]       latch_q,     latch_d;
    logic             full_q,      full_d;
    logic             irq_pend_q,  irq_pend_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             int_n_q,     int_n_d;

    // Scroll write: low byte needs LDS, the two high bits also need UDS.
    function automatic logic [9:0] scroll_next(input logic [9:0]  cur,
                                               input logic [15:0] din,
                                               input logic        uds_n,
                                               input logic        lds_n);
        logic [9:0] nxt;
        nxt = cur;
        if (!lds_n) begin
            nxt[7:0] = din[7:0];
            if (!uds_n) begin
                nxt[9:8] = din[9:8];
            end
        end
        return nxt;
    endfunction

    assign sel = {bus.irq_ack_cs, bus.sound_latch_cs, bus.fg_scroll_y_cs,
                  bus.fg_scroll_x_cs, bus.bg_scroll_y_cs, bus.bg_scroll_x_cs,
                  bus.irq_z80_cs};

    // A write is in progress when RW is low and at least one data strobe is low;
    // only the first cycle of it produces a strobe, so a long AS updates once.
    assign wr_cycle    = ~bus.m68k_rw & ~(bus.m68k_uds_n & bus.m68k_lds_n);
    assign wr_lvl      = sel & {NSEL{wr_cycle}};
    assign strobe      = wr_lvl & ~wr_q;
    assign vbl_rise    = bus.vbl & ~vbl_q;
    assign clr_pulse   = bus.z80_latch_clr_cs & ~clr_q;
    assign z80_ack_lvl = ~bus.z80_m1_n & ~bus.z80_iorq_n;
    assign z80_ack     = z80_ack_lvl & ~ack_q;
    assign term        = (cnt_q == CNT_LAST);
    assign irq_level   = (bus.pcb == 3'd2) ? 3'd2 : 3'd1;

    // Next-state for all registers; later assignments carry priority.
    always_comb begin
        wr_d       = wr_lvl;
        vbl_d      = bus.vbl;
        clr_d      = bus.z80_latch_clr_cs;
        ack_d      = z80_ack_lvl;
        io_reg_d   = io_reg_q;
        bgx_d      = bgx_q;
        bgy_d      = bgy_q;
        fgx_d      = fgx_q;
        fgy_d      = fgy_q;
        latch_d    = latch_q;
        full_d     = full_q;
        irq_pend_d = irq_pend_q;
        cnt_d      = term ? '0 : cnt_q + CNT_W'(1);
        int_n_d    = int_n_q;

        if (strobe[SEL_IO]) begin
            if (!bus.m68k_uds_n) io_reg_d[15:8] = bus.m68k_din[15:8];
            if (!bus.m68k_lds_n) io_reg_d[7:0]  = bus.m68k_din[7:0];
        end
        if (strobe[SEL_BGX]) bgx_d = scroll_next(bgx_q, bus.m68k_din, bus.m68k_uds_n, bus.m68k_lds_n);
        if (strobe[SEL_BGY]) bgy_d = scroll_next(bgy_q, bus.m68k_din, bus.m68k_uds_n, bus.m68k_lds_n);
        if (strobe[SEL_FGX]) fgx_d = scroll_next(fgx_q, bus.m68k_din, bus.m68k_uds_n, bus.m68k_lds_n);
        if (strobe[SEL_FGY]) fgy_d = scroll_next(fgy_q, bus.m68k_din, bus.m68k_uds_n, bus.m68k_lds_n);

        // Z80 clear first so a simultaneous 68k write wins.
        if (clr_pulse) begin
            latch_d = 8'h00;
            full_d  = 1'b0;
        end
        if (strobe[SEL_SND] && !bus.m68k_lds_n) begin
            latch_d = bus.m68k_din[7:0];
            full_d  = 1'b1;
        end

        // Ack first so a coincident vblank edge keeps the request pending.
        if (strobe[SEL_ACK]) irq_pend_d = 1'b0;
        if (vbl_rise)        irq_pend_d = 1'b1;

        // Ack first so a coincident terminal count keeps INT asserted.
        if (z80_ack) int_n_d = 1'b1;
        if (term)    int_n_d = 1'b0;
    end

    // State register; reset also clears the edge detectors.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            wr_q       <= '0;
            vbl_q      <= 1'b0;
            clr_q      <= 1'b0;
            ack_q      <= 1'b0;
            io_reg_q   <= 16'h0000;
            bgx_q      <= 10'h000;
            bgy_q      <= 10'h000;
            fgx_q      <= 10'h000;
            fgy_q      <= 10'h000;
            latch_q    <= 8'h00;
            full_q     <= 1'b0;
            irq_pend_q <= 1'b0;
            cnt_q      <= '0;
            int_n_q    <= 1'b1;
        end else begin
            wr_q       <= wr_d;
            vbl_q      <= vbl_d;
            clr_q      <= clr_d;
            ack_q      <= ack_d;
            io_reg_q   <= io_reg_d;
            bgx_q      <= bgx_d;
            bgy_q      <= bgy_d;
            fgx_q      <= fgx_d;
            fgy_q      <= fgy_d;
            latch_q    <= latch_d;
            full_q     <= full_d;
            irq_pend_q <= irq_pend_d;
            cnt_q      <= cnt_d;
            int_n_q    <= int_n_d;
        end
    end

    assign bus.m68k_ipl_n     = irq_pend_q ? ~irq_level : 3'b111;
    assign bus.z80_int_n      = int_n_q;
    assign bus.z80_latch_dout = bus.z80_latch_r_cs ? latch_q : 8'h00;
    assign bus.latch_full     = full_q;
    assign bus.io_reg         = io_reg_q;
    assign bus.flip_screen    = io_reg_q[12];
    assign bus.bg_scroll_x    = bgx_q;
    assign bus.bg_scroll_y    = bgy_q;
    assign bus.fg_scroll_x    = fgx_q;
    assign bus.fg_scroll_y    = fgy_q;

endmodule
`default_nettype wire

// File: tb/tb_m68k_io_latch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_m68k_io_latch
//  Purpose  : Directed self-checking bench for m68k_io_latch (Z80_IRQ_DIV=16).
//  Revision : 1.0  initial release
// ============================================================================
module tb_m68k_io_latch;

    localparam int SEL_IO  = 0;
    localparam int SEL_BGX = 1;
    localparam int SEL_BGY = 2;
    localparam int SEL_FGX = 3;
    localparam int SEL_FGY = 4;
    localparam int SEL_SND = 5;
    localparam int SEL_ACK = 6;

    logic       clk;
    logic       rst;
    logic [6:0] sel;
    int         ecount;
    int         vectors;
    int         miscompares;

    m68k_io_latch_if bus ();

    m68k_io_latch #(.Z80_IRQ_DIV(16)) dut (
        .clk_sys (clk),
        .reset   (rst),
        .bus     (bus)
    );

    assign bus.irq_z80_cs     = sel[SEL_IO];
    assign bus.bg_scroll_x_cs = sel[SEL_BGX];
    assign bus.bg_scroll_y_cs = sel[SEL_BGY];
    assign bus.fg_scroll_x_cs = sel[SEL_FGX];
    assign bus.fg_scroll_y_cs = sel[SEL_FGY];
    assign bus.sound_latch_cs = sel[SEL_SND];
    assign bus.irq_ack_cs     = sel[SEL_ACK];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rising edges since reset release.
    always @(posedge clk or posedge rst) begin
        if (rst) ecount <= 0;
        else     ecount <= ecount + 1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_edge(input int n);
        while (ecount < n) tick;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input int idx, input logic [15:0] data,
                             input logic uds, input logic lds, input int hold);
        bus.m68k_din   = data;
        bus.m68k_rw    = 1'b0;
        bus.m68k_uds_n = uds;
        bus.m68k_lds_n = lds;
        sel            = 7'b1 << idx;
        repeat (hold) tick;
        sel            = 7'b0;
        bus.m68k_rw    = 1'b1;
        bus.m68k_uds_n = 1'b1;
        bus.m68k_lds_n = 1'b1;
        tick;
    endtask

    initial begin
        vectors              = 0;
        miscompares          = 0;
        rst                  = 1'b1;
        sel                  = 7'b0;
        bus.pcb              = 3'd1;
        bus.m68k_din         = 16'h0000;
        bus.m68k_rw          = 1'b1;
        bus.m68k_uds_n       = 1'b1;
        bus.m68k_lds_n       = 1'b1;
        bus.vbl              = 1'b0;
        bus.z80_latch_r_cs   = 1'b1;
        bus.z80_latch_clr_cs = 1'b0;
        bus.z80_m1_n         = 1'b1;
        bus.z80_iorq_n       = 1'b1;
        repeat (3) tick;

        // Reset state
        check("rst_ipl",   16'(bus.m68k_ipl_n), 16'h0007);
        check("rst_int",   16'(bus.z80_int_n), 16'h0001);
        check("rst_full",  16'(bus.latch_full), 16'h0000);
        check("rst_dout",  16'(bus.z80_latch_dout), 16'h0000);
        check("rst_io",    bus.io_reg, 16'h0000);
        check("rst_bgx",   16'(bus.bg_scroll_x), 16'h0000);

        // Z80 periodic IRQ
        rst = 1'b0;
        wait_edge(15);
        check("zint_e15", 16'(bus.z80_int_n), 16'h0001);
        wait_edge(16);
        check("zint_e16", 16'(bus.z80_int_n), 16'h0000);
        wait_edge(21);
        check("zint_hold", 16'(bus.z80_int_n), 16'h0000);
        bus.z80_m1_n = 1'b0; bus.z80_iorq_n = 1'b0;
        wait_edge(22);
        check("zint_ack", 16'(bus.z80_int_n), 16'h0001);
        wait_edge(23);
        bus.z80_m1_n = 1'b1; bus.z80_iorq_n = 1'b1;
        wait_edge(31);
        check("zint_e31", 16'(bus.z80_int_n), 16'h0001);
        wait_edge(32);
        check("zint_e32", 16'(bus.z80_int_n), 16'h0000);
        wait_edge(47);
        bus.z80_m1_n = 1'b0; bus.z80_iorq_n = 1'b0;
        wait_edge(48);
        check("zint_tc_ack", 16'(bus.z80_int_n), 16'h0000);
        wait_edge(50);
        bus.z80_m1_n = 1'b1; bus.z80_iorq_n = 1'b1;
        wait_edge(51);
        bus.z80_m1_n = 1'b0; bus.z80_iorq_n = 1'b0;
        wait_edge(52);
        check("zint_ack2", 16'(bus.z80_int_n), 16'h0001);
        bus.z80_m1_n = 1'b1; bus.z80_iorq_n = 1'b1;

        // Sound latch, AS held 5 cycles
        bus.z80_latch_r_cs = 1'b0;
        bus_write(SEL_SND, 16'h1234, 1'b0, 1'b0, 5);
        check("snd_full", 16'(bus.latch_full), 16'h0001);
        check("snd_dout_noread", 16'(bus.z80_latch_dout), 16'h0000);
        bus.z80_latch_r_cs = 1'b1;
        #1;
        check("snd_dout", 16'(bus.z80_latch_dout), 16'h0034);
        bus.z80_latch_clr_cs = 1'b1;
        tick;
        bus.z80_latch_clr_cs = 1'b0;
        check("clr_dout", 16'(bus.z80_latch_dout), 16'h0000);
        check("clr_full", 16'(bus.latch_full), 16'h0000);
        tick;

        // One update per bus cycle: clear while the select is still held
        bus.m68k_din = 16'h5678; bus.m68k_rw = 1'b0;
        bus.m68k_uds_n = 1'b0; bus.m68k_lds_n = 1'b0;
        sel = 7'b1 << SEL_SND;
        tick;
        check("once_dout", 16'(bus.z80_latch_dout), 16'h0078);
        bus.z80_latch_clr_cs = 1'b1;
        tick;
        bus.z80_latch_clr_cs = 1'b0;
        repeat (3) tick;
        check("once_full", 16'(bus.latch_full), 16'h0000);
        check("once_dout2", 16'(bus.z80_latch_dout), 16'h0000);
        sel = 7'b0; bus.m68k_rw = 1'b1;
        bus.m68k_uds_n = 1'b1; bus.m68k_lds_n = 1'b1;
        tick;

        // 68k vblank IRQ and level per board
        bus.pcb = 3'd2;
        bus.vbl = 1'b1;
        tick;
        check("ipl_pcb2", 16'(bus.m68k_ipl_n), 16'h0005);
        bus.pcb = 3'd0;
        #1;
        check("ipl_pcbchg", 16'(bus.m68k_ipl_n), 16'h0006);
        bus.pcb = 3'd2;
        bus_write(SEL_ACK, 16'h0000, 1'b0, 1'b0, 2);
        check("ipl_ack", 16'(bus.m68k_ipl_n), 16'h0007);
        bus.pcb = 3'd0;
        bus.vbl = 1'b0;
        tick;
        bus.vbl = 1'b1;
        tick;
        check("ipl_pcb0", 16'(bus.m68k_ipl_n), 16'h0006);
        bus_write(SEL_ACK, 16'h0000, 1'b0, 1'b0, 2);
        check("ipl_ack0", 16'(bus.m68k_ipl_n), 16'h0007);

        // Vblank edge coincident with ack strobe
        bus.vbl = 1'b0;
        tick;
        bus.vbl = 1'b1;
        bus.m68k_din = 16'h0000; bus.m68k_rw = 1'b0;
        bus.m68k_uds_n = 1'b0; bus.m68k_lds_n = 1'b0;
        sel = 7'b1 << SEL_ACK;
        tick;
        sel = 7'b0; bus.m68k_rw = 1'b1;
        bus.m68k_uds_n = 1'b1; bus.m68k_lds_n = 1'b1;
        tick;
        check("ipl_setwins", 16'(bus.m68k_ipl_n), 16'h0006);
        bus_write(SEL_ACK, 16'h0000, 1'b0, 1'b0, 1);
        check("ipl_ack2", 16'(bus.m68k_ipl_n), 16'h0007);

        // Latch write coincident with Z80 clear
        bus.m68k_din = 16'h00AB; bus.m68k_rw = 1'b0;
        bus.m68k_uds_n = 1'b1; bus.m68k_lds_n = 1'b0;
        sel = 7'b1 << SEL_SND;
        bus.z80_latch_clr_cs = 1'b1;
        tick;
        sel = 7'b0; bus.m68k_rw = 1'b1; bus.m68k_lds_n = 1'b1;
        bus.z80_latch_clr_cs = 1'b0;
        check("wrclr_full", 16'(bus.latch_full), 16'h0001);
        check("wrclr_dout", 16'(bus.z80_latch_dout), 16'h00AB);
        tick;
        bus_write(SEL_SND, 16'h00CD, 1'b0, 1'b1, 2);
        check("snd_uds_only", 16'(bus.z80_latch_dout), 16'h00AB);

        // Video control word and scroll byte lanes
        bus_write(SEL_IO, 16'h1000, 1'b0, 1'b1, 2);
        check("io_upper", bus.io_reg, 16'h1000);
        check("io_flip", 16'(bus.flip_screen), 16'h0001);
        bus_write(SEL_IO, 16'hFFFF, 1'b1, 1'b0, 2);
        check("io_lower", bus.io_reg, 16'h10FF);
        bus_write(SEL_BGX, 16'h03FF, 1'b0, 1'b0, 2);
        check("bgx_both", 16'(bus.bg_scroll_x), 16'h03FF);
        bus_write(SEL_BGY, 16'h03FF, 1'b1, 1'b0, 2);
        check("bgy_lds", 16'(bus.bg_scroll_y), 16'h00FF);
        bus_write(SEL_FGX, 16'h03FF, 1'b0, 1'b1, 2);
        check("fgx_uds", 16'(bus.fg_scroll_x), 16'h0000);
        bus_write(SEL_FGY, 16'h02AA, 1'b0, 1'b0, 2);
        check("fgy_both", 16'(bus.fg_scroll_y), 16'h02AA);

        // Reset in the middle of a held write
        bus.m68k_din = 16'h00C3; bus.m68k_rw = 1'b0;
        bus.m68k_uds_n = 1'b0; bus.m68k_lds_n = 1'b0;
        sel = 7'b1 << SEL_IO;
        tick;
        check("pre_rst_io", bus.io_reg, 16'h00C3);
        #3;
        rst = 1'b1;
        #1;
        check("mid_rst_io",   bus.io_reg, 16'h0000);
        check("mid_rst_flip", 16'(bus.flip_screen), 16'h0000);
        check("mid_rst_bgx",  16'(bus.bg_scroll_x), 16'h0000);
        check("mid_rst_fgy",  16'(bus.fg_scroll_y), 16'h0000);
        check("mid_rst_full", 16'(bus.latch_full), 16'h0000);
        check("mid_rst_dout", 16'(bus.z80_latch_dout), 16'h0000);
        check("mid_rst_ipl",  16'(bus.m68k_ipl_n), 16'h0007);
        check("mid_rst_int",  16'(bus.z80_int_n), 16'h0001);
        tick;
        rst = 1'b0;
        tick;
        check("post_rst_strobe", bus.io_reg, 16'h00C3);
        sel = 7'b0; bus.m68k_rw = 1'b1;
        bus.m68k_uds_n = 1'b1; bus.m68k_lds_n = 1'b1;
        tick;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
